lsu_mc: RTL and testbench
=========================

Name: lsu_mc

Overview:
- Parametrised, multicycle successor to the pipeline's combinational load/store unit.
- Accepts one load/store per transaction from EXE and drives a req/gnt/rvalid data-memory port.
- Splits misaligned accesses into two aligned beats when enabled; otherwise flags them as an error.
- Lane-aligns and sign/zero-extends read data, then returns a writeback packet to the register file.
- Sits between the EXE stage and the data memory/bus.

Parameters:
- XLEN, 32, data width; 32 or 64.
- NB, XLEN/8, byte lanes (derived).
- OFF_W, $clog2(NB), byte-offset width (derived).
- ADDR_W, 32, address width.
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into two beats; 0 = raise err.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  EXE request valid.
- req_ready_o  out  1  LSU can accept a request (state IDLE).
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = double (XLEN=64 only).
- req_unsigned_i  in  1  zero-extend load result.
- req_addr_i  in  ADDR_W  byte address (EXE ALU output).
- req_wdata_i  in  XLEN  store data, LSB-justified.
- req_rd_i  in  5  destination register.
- dmem_req_o  out  1  memory request.
- dmem_gnt_i  in  1  memory grant.
- dmem_we_o  out  1  memory write.
- dmem_be_o  out  NB  byte enables.
- dmem_addr_o  out  ADDR_W  address, NB-aligned.
- dmem_wdata_o  out  XLEN  lane-shifted write data.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  read data.
- wb_valid_o  out  1  one-cycle completion pulse.
- wb_we_o  out  1  register write enable (load without error).
- wb_rd_o  out  5  destination register.
- wb_data_o  out  XLEN  extended load result.
- err_o  out  1  misaligned access with SPLIT_MISALIGNED=0; qualified by wb_valid_o.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0.
  - wb_valid_o=0, wb_we_o=0, wb_rd_o=0, wb_data_o=0, err_o=0; all captured fields cleared.
- Reset mid-operation abandons the transaction. Grants and rvalid received while in IDLE are ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture addr, size, we, unsigned, rd and wdata.
  - Compute off = addr[OFF_W-1:0] and bytes = 1<<size. Misaligned means off + bytes > NB.
  - Misaligned with SPLIT_MISALIGNED=0: go to RESP with err=1 and no memory access.
  - Otherwise: beat=0, go to ISSUE.
- Beat generation:
  - Build a 2*NB-bit mask ((1<<bytes)-1) << off and 2*XLEN-bit data wdata << (off*8).
  - Beat 0 uses the low halves; beat 1 uses the high halves.
  - dmem_addr_o = aligned address + beat*NB.
  - A second beat is required when the high mask is nonzero.
- ISSUE:
  - dmem_req_o=1, held with stable addr/be/wdata/we until dmem_gnt_i.
  - Store granted: go to ISSUE (beat 1) if needed, else RESP.
  - Load granted: go to WAIT.
- WAIT:
  - dmem_req_o=0.
  - On dmem_rvalid_i, store rdata into slot[beat]. Go to ISSUE (beat 1) if needed, else RESP.
  - Only one access is outstanding; rvalid arrives at the earliest the cycle after gnt.
- RESP:
  - Registered outputs: wb_valid_o=1 for exactly one cycle, then IDLE.
  - Result: {slot1,slot0} >> (off*8), truncated to bytes*8, then sign-extended (req_unsigned_i=0) or zero-extended.
  - wb_we_o = load & !err. wb_rd_o = captured rd.
  - Stores report completion with wb_we_o=0 and wb_data_o=0.
- Latency (gnt and rvalid each at the earliest cycle):
  - Aligned load: accept T0, req T1, rvalid T2, wb_valid T3.
  - Split load: wb_valid T5.
  - Aligned store: wb_valid T2.
- req_valid_i while not IDLE is not accepted; EXE holds it.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - state enum.
  - function size_bytes().
- Sub-module lsu_align (combinational):
  - Inputs: off, size, wdata.
  - Outputs: 2-beat byte enables, 2-beat lane-shifted write data, split flag.
  - Reused for read-data extraction and extension.

Test Plan:
- XLEN=32 aligned word load: addr 0x100, mem word 0xDEADBEEF, gnt same cycle, rvalid next → wb_valid at T3, wb_data_o 0xDEADBEEF, wb_we_o 1.
- Signed byte load: addr 0x103, word 0x80FF0000 → be 4'b1000, wb_data_o 0xFFFFFF80. With unsigned → 0x00000080.
- Split word store: addr 0x102, wdata 0xAABBCCDD.
  - Beat 0: addr 0x100, be 4'b1100, wdata 0xCCDD0000.
  - Beat 1: addr 0x104, be 4'b0011, wdata 0x0000AABB.
  - wb_we_o 0.
- Split half load: addr 0x0FF, words 0x11xxxxxx / 0xxxxxxx22 → wb_data_o 0x00002211.
- SPLIT_MISALIGNED=0, word load at 0x101 → no dmem_req_o, wb_valid with err_o 1 and wb_we_o 0. gnt delayed 3 cycles holds addr/be stable.
- rst_n low while in WAIT → outputs zero immediately; later stale rvalid is ignored and the next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the multicycle load/store unit: size encodings, FSM states
// and the access-size helper.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_mc_if.sv
// EXE-side request/writeback bundle and data-memory req/gnt/rvalid bundle.
// Master is the initiator of each bundle (EXE for requests, LSU for memory).
interface lsu_req_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic [4:0]        req_rd_i;
  logic              wb_valid_o;
  logic              wb_we_o;
  logic [4:0]        wb_rd_o;
  logic [XLEN-1:0]   wb_data_o;
  logic              err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, err_o
  );
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, err_o
  );
endinterface

interface lsu_dmem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              dmem_req_o;
  logic              dmem_gnt_i;
  logic              dmem_we_o;
  logic [NB-1:0]     dmem_be_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic [XLEN-1:0]   dmem_wdata_o;
  logic              dmem_rvalid_i;
  logic [XLEN-1:0]   dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: two-beat byte enables and write data for a
// possibly misaligned access, plus extraction/extension of the read result.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata_lo,
  input  logic [XLEN-1:0]  rdata_hi,
  input  logic             uns,
  output logic [NB-1:0]    be_lo,
  output logic [NB-1:0]    be_hi,
  output logic [XLEN-1:0]  wd_lo,
  output logic [XLEN-1:0]  wd_hi,
  output logic             split,
  output logic [XLEN-1:0]  rdata_ext
);

  logic [3:0]        nbytes;
  logic [2*NB-1:0]   base_mask;
  logic [2*NB-1:0]   mask;
  logic [2*XLEN-1:0] wd_full;
  logic [2*XLEN-1:0] rd_shift;
  logic              sign_bit;
  logic              fill;

  assign nbytes = size_bytes(size);

  // base_mask[i] is set for the first nbytes lanes of the access itself.
  for (genvar gi = 0; gi < 2*NB; gi++) begin : g_mask
    assign base_mask[gi] = ({28'd0, nbytes} > 32'(gi));
  end

  assign mask    = base_mask << off;
  assign wd_full = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign be_lo   = mask[NB-1:0];
  assign be_hi   = mask[2*NB-1:NB];
  assign wd_lo   = wd_full[XLEN-1:0];
  assign wd_hi   = wd_full[2*XLEN-1:XLEN];
  assign split   = |be_hi;

  assign rd_shift = {rdata_hi, rdata_lo} >> {off, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    unique case (size)
      SZ_B:    sign_bit = rd_shift[7];
      SZ_H:    sign_bit = rd_shift[15];
      SZ_W:    sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[63];
    endcase
  end

  assign fill = sign_bit & ~uns;

  for (genvar gi = 0; gi < NB; gi++) begin : g_ext
    assign rdata_ext[gi*8 +: 8] = base_mask[gi] ? rd_shift[gi*8 +: 8] : {8{fill}};
  end

endmodule

// File: rtl/lsu_mc.sv
// Multicycle load/store unit: one EXE transaction at a time, split into up to
// two aligned req/gnt/rvalid beats, with a registered one-cycle writeback.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int NB               = XLEN / 8,
  parameter int OFF_W            = $clog2(NB),
  parameter int ADDR_W           = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_req_if.slave     req,
  lsu_dmem_if.master   dmem
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        size_reg, size_next;
  logic              we_reg, we_next;
  logic              uns_reg, uns_next;
  logic [4:0]        rd_reg, rd_next;
  logic [XLEN-1:0]   wdata_reg, wdata_next;
  logic              beat_reg, beat_next;
  logic [XLEN-1:0]   slot0_reg, slot0_next;
  logic [XLEN-1:0]   slot1_reg, slot1_next;
  logic              wb_valid_reg, wb_valid_next;
  logic              wb_we_reg, wb_we_next;
  logic              wb_err_reg, wb_err_next;
  logic [4:0]        wb_rd_reg, wb_rd_next;
  logic [XLEN-1:0]   wb_data_reg, wb_data_next;

  logic [OFF_W-1:0]  off_in;
  logic              misaligned_in;
  logic [NB-1:0]     be_lo, be_hi;
  logic [XLEN-1:0]   wd_lo, wd_hi, rdata_ext;
  logic              split, need_beat1, resp_go, issue, rd_capture;
  logic [ADDR_W-1:0] beat_addr;

  assign off_in        = req.req_addr_i[OFF_W-1:0];
  assign misaligned_in = ({28'd0, size_bytes(req.req_size_i)} + 32'(off_in)) > 32'(NB);

  // Read data lands in the slots combinationally so the writeback register
  // can capture the extended result on the same edge as the final rvalid.
  assign rd_capture = (state_reg == WAIT) && dmem.dmem_rvalid_i;
  assign slot0_next = (rd_capture && !beat_reg) ? dmem.dmem_rdata_i : slot0_reg;
  assign slot1_next = (rd_capture &&  beat_reg) ? dmem.dmem_rdata_i : slot1_reg;

  lsu_align #(.XLEN(XLEN), .NB(NB), .OFF_W(OFF_W)) u_align (
    .off       (addr_reg[OFF_W-1:0]),
    .size      (size_reg),
    .wdata     (wdata_reg),
    .rdata_lo  (slot0_next),
    .rdata_hi  (slot1_next),
    .uns       (uns_reg),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .wd_lo     (wd_lo),
    .wd_hi     (wd_hi),
    .split     (split),
    .rdata_ext (rdata_ext)
  );

  assign need_beat1 = !beat_reg && split;
  assign beat_addr  = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + (beat_reg ? ADDR_W'(NB) : '0);

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    size_next     = size_reg;
    we_next       = we_reg;
    uns_next      = uns_reg;
    rd_next       = rd_reg;
    wdata_next    = wdata_reg;
    beat_next     = beat_reg;
    wb_valid_next = 1'b0;
    wb_we_next    = 1'b0;
    wb_err_next   = 1'b0;
    wb_rd_next    = wb_rd_reg;
    wb_data_next  = wb_data_reg;
    resp_go       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (req.req_valid_i) begin
          addr_next  = req.req_addr_i;
          size_next  = req.req_size_i;
          we_next    = req.req_we_i;
          uns_next   = req.req_unsigned_i;
          rd_next    = req.req_rd_i;
          wdata_next = req.req_wdata_i;
          beat_next  = 1'b0;
          if (misaligned_in && (SPLIT_MISALIGNED == 0)) begin
            state_next    = RESP;
            wb_valid_next = 1'b1;
            wb_err_next   = 1'b1;
            wb_rd_next    = req.req_rd_i;
            wb_data_next  = '0;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (dmem.dmem_gnt_i) begin
          if (!we_reg)         state_next = WAIT;
          else if (need_beat1) beat_next  = 1'b1;
          else                 resp_go    = 1'b1;
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid_i) begin
          if (need_beat1) begin
            beat_next  = 1'b1;
            state_next = ISSUE;
          end else begin
            resp_go = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (resp_go) begin
      state_next    = RESP;
      wb_valid_next = 1'b1;
      wb_we_next    = !we_reg;
      wb_rd_next    = rd_reg;
      wb_data_next  = we_reg ? '0 : rdata_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      size_reg     <= '0;
      we_reg       <= 1'b0;
      uns_reg      <= 1'b0;
      rd_reg       <= '0;
      wdata_reg    <= '0;
      beat_reg     <= 1'b0;
      slot0_reg    <= '0;
      slot1_reg    <= '0;
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_err_reg   <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      size_reg     <= size_next;
      we_reg       <= we_next;
      uns_reg      <= uns_next;
      rd_reg       <= rd_next;
      wdata_reg    <= wdata_next;
      beat_reg     <= beat_next;
      slot0_reg    <= slot0_next;
      slot1_reg    <= slot1_next;
      wb_valid_reg <= wb_valid_next;
      wb_we_reg    <= wb_we_next;
      wb_err_reg   <= wb_err_next;
      wb_rd_reg    <= wb_rd_next;
      wb_data_reg  <= wb_data_next;
    end
  end

  // Memory outputs are forced to zero outside ISSUE so an abandoned or idle
  // unit never presents a stale beat.
  assign issue             = (state_reg == ISSUE);
  assign dmem.dmem_req_o   = issue;
  assign dmem.dmem_we_o    = issue && we_reg;
  assign dmem.dmem_be_o    = issue ? (beat_reg ? be_hi : be_lo) : '0;
  assign dmem.dmem_addr_o  = issue ? beat_addr : '0;
  assign dmem.dmem_wdata_o = (issue && we_reg) ? (beat_reg ? wd_hi : wd_lo) : '0;

  assign req.req_ready_o = (state_reg == IDLE);
  assign req.wb_valid_o  = wb_valid_reg;
  assign req.wb_we_o     = wb_we_reg;
  assign req.wb_rd_o     = wb_rd_reg;
  assign req.wb_data_o   = wb_data_reg;
  assign req.err_o       = wb_err_reg;

endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc: one splitting and one non-splitting instance,
// driven from a shared vector table with a cycle-accurate memory responder.
module tb_lsu_mc;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int NV     = 17;

  typedef struct {
    bit          dut;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] r0;
    logic [31:0] r1;
    int          gdly;
    int          nbeats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] data;
    bit          wbwe;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vecs [NV];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic [4:0]  rd = '0;
  logic        gnt = 1'b0, rvalid = 1'b0;

  int passed = 0;
  int total  = 0;

  lsu_req_if  #(.XLEN(XLEN), .ADDR_W(ADDR_W)) req_a ();
  lsu_req_if  #(.XLEN(XLEN), .ADDR_W(ADDR_W)) req_b ();
  lsu_dmem_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dm_a ();
  lsu_dmem_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dm_b ();

  lsu_mc #(.XLEN(XLEN), .ADDR_W(ADDR_W), .SPLIT_MISALIGNED(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .dmem(dm_a));
  lsu_mc #(.XLEN(XLEN), .ADDR_W(ADDR_W), .SPLIT_MISALIGNED(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .dmem(dm_b));

  assign req_a.req_valid_i    = req_valid & ~sel;
  assign req_b.req_valid_i    = req_valid & sel;
  assign req_a.req_we_i       = we;
  assign req_b.req_we_i       = we;
  assign req_a.req_size_i     = size;
  assign req_b.req_size_i     = size;
  assign req_a.req_unsigned_i = uns;
  assign req_b.req_unsigned_i = uns;
  assign req_a.req_addr_i     = addr;
  assign req_b.req_addr_i     = addr;
  assign req_a.req_wdata_i    = wdata;
  assign req_b.req_wdata_i    = wdata;
  assign req_a.req_rd_i       = rd;
  assign req_b.req_rd_i       = rd;
  assign dm_a.dmem_gnt_i      = gnt & ~sel;
  assign dm_b.dmem_gnt_i      = gnt & sel;
  assign dm_a.dmem_rvalid_i   = rvalid & ~sel;
  assign dm_b.dmem_rvalid_i   = rvalid & sel;
  assign dm_a.dmem_rdata_i    = rdata;
  assign dm_b.dmem_rdata_i    = rdata;

  logic        o_ready, o_dreq, o_dwe, o_wbv, o_wbwe, o_err;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_wbdata;
  logic [4:0]  o_rd;
  assign o_ready  = sel ? req_b.req_ready_o : req_a.req_ready_o;
  assign o_wbv    = sel ? req_b.wb_valid_o  : req_a.wb_valid_o;
  assign o_wbwe   = sel ? req_b.wb_we_o     : req_a.wb_we_o;
  assign o_rd     = sel ? req_b.wb_rd_o     : req_a.wb_rd_o;
  assign o_wbdata = sel ? req_b.wb_data_o   : req_a.wb_data_o;
  assign o_err    = sel ? req_b.err_o       : req_a.err_o;
  assign o_dreq   = sel ? dm_b.dmem_req_o   : dm_a.dmem_req_o;
  assign o_dwe    = sel ? dm_b.dmem_we_o    : dm_a.dmem_we_o;
  assign o_be     = sel ? dm_b.dmem_be_o    : dm_a.dmem_be_o;
  assign o_addr   = sel ? dm_b.dmem_addr_o  : dm_a.dmem_addr_o;
  assign o_wdata  = sel ? dm_b.dmem_wdata_o : dm_a.dmem_wdata_o;

  task automatic chk(input int idx, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL v%0d %s: got 0x%0h need 0x%0h", idx, name, act, exp);
  endtask

  task automatic chk_idle(input int idx);
    chk(idx, "idle_dreq",  o_dreq,   0);
    chk(idx, "idle_dbus",  {o_dwe, o_be, o_addr, o_wdata}, 0);
    chk(idx, "idle_wbv",   o_wbv,    0);
    chk(idx, "idle_wb",    {o_wbwe, o_rd, o_wbdata, o_err}, 0);
    chk(idx, "idle_ready", o_ready,  1);
  endtask

  task automatic run(input vec_t v, input int idx);
    int t, nb, wcnt;
    bit done, pend_rv, holding;
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [3:0]  rb [2];
    logic        rwe [2];
    @(negedge clk);
    sel = v.dut;
    #1;
    chk(idx, "ready", o_ready, 1);
    req_valid = 1'b1; we = v.we; size = v.size; uns = v.uns;
    addr = v.addr; wdata = v.wdata; rd = v.rd;
    @(negedge clk);
    req_valid = 1'b0;
    t = 1; nb = 0; wcnt = 0; done = 0; pend_rv = 0; holding = 0;
    while (!done && t < 40) begin
      gnt = 1'b0; rvalid = 1'b0;
      if (pend_rv) begin
        rvalid = 1'b1;
        rdata  = (nb <= 1) ? v.r0 : v.r1;
        pend_rv = 0;
      end
      if (o_wbv) begin
        done = 1;
      end else if (o_dreq) begin
        if (!holding) begin
          if (nb < 2) begin
            ra[nb] = o_addr; rb[nb] = o_be; rw[nb] = o_wdata; rwe[nb] = o_dwe;
          end
          nb++; wcnt = 0; holding = 1;
        end else if (nb <= 2) begin
          chk(idx, "hold_addr", o_addr, ra[nb-1]);
          chk(idx, "hold_be",   o_be,   rb[nb-1]);
        end
        if (wcnt == v.gdly) begin
          gnt = 1'b1; holding = 0;
          if (!v.we) pend_rv = 1;
        end else begin
          wcnt++;
        end
      end
      if (!done) begin
        @(negedge clk);
        t++;
      end
    end
    gnt = 1'b0; rvalid = 1'b0;
    chk(idx, "timeout", done, 1);
    chk(idx, "nbeats", nb, v.nbeats);
    if (v.nbeats >= 1 && nb >= 1) begin
      chk(idx, "addr0", ra[0], v.a0);
      chk(idx, "be0",   rb[0], v.be0);
      chk(idx, "we0",   rwe[0], v.we);
      if (v.we) chk(idx, "wdata0", rw[0], v.wd0);
    end
    if (v.nbeats >= 2 && nb >= 2) begin
      chk(idx, "addr1", ra[1], v.a1);
      chk(idx, "be1",   rb[1], v.be1);
      chk(idx, "we1",   rwe[1], v.we);
      if (v.we) chk(idx, "wdata1", rw[1], v.wd1);
    end
    if (!v.err) chk(idx, "wb_data", o_wbdata, v.data);
    chk(idx, "wb_we",   o_wbwe, v.wbwe);
    chk(idx, "wb_rd",   o_rd,   v.rd);
    chk(idx, "err",     o_err,  v.err);
    chk(idx, "latency", t,      v.lat);
    $display("txn %0d dut=%0d we=%0d size=%0d addr=0x%08h beats=%0d wb_data=0x%08h err=%0d lat=%0d",
             idx, v.dut, v.we, v.size, v.addr, nb, o_wbdata, o_err, t);
    @(negedge clk);
    chk(idx, "pulse", o_wbv, 0);
    chk(idx, "back_idle", o_ready, 1);
  endtask

  initial begin
    // dut we size uns addr wdata rd r0 r1 gdly nbeats a0 be0 wd0 a1 be1 wd1 data wbwe err lat
    vecs[0]  = '{0,0,2,0,'h100,'h0,1,'hDEADBEEF,'h0,0,1,'h100,'hF,'h0,'h0,'h0,'h0,'hDEADBEEF,1,0,3};
    vecs[1]  = '{0,0,0,0,'h103,'h0,2,'h80FF0000,'h0,0,1,'h100,'h8,'h0,'h0,'h0,'h0,'hFFFFFF80,1,0,3};
    vecs[2]  = '{0,0,0,1,'h103,'h0,3,'h80FF0000,'h0,0,1,'h100,'h8,'h0,'h0,'h0,'h0,'h00000080,1,0,3};
    vecs[3]  = '{0,1,2,0,'h102,'hAABBCCDD,4,'h0,'h0,0,2,'h100,'hC,'hCCDD0000,'h104,'h3,'h0000AABB,'h0,0,0,3};
    vecs[4]  = '{0,0,1,0,'h0FF,'h0,5,'h11000000,'h00000022,0,2,'h0FC,'h8,'h0,'h100,'h1,'h0,'h00002211,1,0,5};
    vecs[5]  = '{0,1,2,0,'h108,'h12345678,6,'h0,'h0,0,1,'h108,'hF,'h12345678,'h0,'h0,'h0,'h0,0,0,2};
    vecs[6]  = '{0,1,0,0,'h101,'h000000A5,7,'h0,'h0,0,1,'h100,'h2,'h0000A500,'h0,'h0,'h0,'h0,0,0,2};
    vecs[7]  = '{0,0,1,0,'h102,'h0,8,'h80011234,'h0,0,1,'h100,'hC,'h0,'h0,'h0,'h0,'hFFFF8001,1,0,3};
    vecs[8]  = '{0,0,1,1,'h102,'h0,9,'h80011234,'h0,0,1,'h100,'hC,'h0,'h0,'h0,'h0,'h00008001,1,0,3};
    vecs[9]  = '{0,1,1,0,'h103,'h0000BEEF,10,'h0,'h0,0,2,'h100,'h8,'hEF000000,'h104,'h1,'h000000BE,'h0,0,0,3};
    vecs[10] = '{0,0,2,0,'h101,'h0,11,'hDDCCBBAA,'h000000EE,0,2,'h100,'hE,'h0,'h104,'h1,'h0,'hEEDDCCBB,1,0,5};
    vecs[11] = '{0,0,0,0,'h0FD,'h0,12,'h00007F00,'h0,0,1,'h0FC,'h2,'h0,'h0,'h0,'h0,'h0000007F,1,0,3};
    vecs[12] = '{0,0,2,0,'h104,'h0,13,'hCAFEF00D,'h0,3,1,'h104,'hF,'h0,'h0,'h0,'h0,'hCAFEF00D,1,0,6};
    vecs[13] = '{0,1,0,0,'h103,'h000000FF,14,'h0,'h0,0,1,'h100,'h8,'hFF000000,'h0,'h0,'h0,'h0,0,0,2};
    vecs[14] = '{1,0,2,0,'h101,'h0,15,'h0,'h0,0,0,'h0,'h0,'h0,'h0,'h0,'h0,'h0,0,1,1};
    vecs[15] = '{1,0,1,0,'h102,'h0,16,'h80011234,'h0,0,1,'h100,'hC,'h0,'h0,'h0,'h0,'hFFFF8001,1,0,3};
    vecs[16] = '{1,1,1,0,'h103,'h0000BEEF,17,'h0,'h0,0,0,'h0,'h0,'h0,'h0,'h0,'h0,'h0,0,1,1};

    #2;
    sel = 1'b0; #1 chk_idle(-1);
    sel = 1'b1; #1 chk_idle(-2);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run(vecs[i], i);

    // Reset while a load waits for rvalid, then a stale rvalid must be ignored.
    @(negedge clk);
    sel = 1'b0;
    req_valid = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 'h100; rd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    chk(-3, "rw_req", o_dreq, 1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk(-3, "rw_wait", o_dreq, 0);
    #2 rst_n = 1'b0;
    #1 chk_idle(-3);
    @(negedge clk);
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 'h55555555;
    @(negedge clk);
    rvalid = 1'b0;
    chk(-3, "stale_wbv0", o_wbv, 0);
    @(negedge clk);
    chk(-3, "stale_wbv1", o_wbv, 0);
    chk(-3, "stale_ready", o_ready, 1);
    run(vecs[0], 99);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
